pve_l1_mem_pwr_seq: RTL and testbench
=====================================

Name: pve_l1_mem_pwr_seq

Overview:
- Initiator at the head of the PVE L1 memory-macro power daisy chain. There are 64 macros in fixed chain order across sub-banks and mini-banks.
- Drives the chain power-down enable into the first macro and watches the power-ready return from the last macro.
- Reports completion, measured chain latency and timeout to the PVE L1 control/CSR logic.
- Serialises power-state change requests so that only one transition is in flight at a time.

Parameters:
- NUM_MACRO, 64, number of macros on the chain; informational, sets LAT_W minimum.
- TIMEOUT_W, 16, width of timeout and latency counters.
- LAT_W, TIMEOUT_W, width of o_latency.

Ports:
- i_clk  in  1  block clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request ready; high only in IDLE
- i_req_pwr_down  in  1  target state: 1 = power down, 0 = power up
- i_timeout_cycles  in  TIMEOUT_W  WAIT limit in cycles; 0 = no timeout; sampled at accept
- o_chain_pde  out  1  chain-head power-down enable (registered)
- i_chain_prn  in  1  chain-tail power-ready return; equals pde level once all macros have settled
- o_pwr_state  out  1  last confirmed chain state; 1 = down
- o_busy  out  1  high in WAIT and RESP
- o_done  out  1  one-cycle pulse: transition confirmed
- o_err_timeout  out  1  one-cycle pulse: transition timed out
- o_latency  out  LAT_W  WAIT-cycle count of last completed or timed-out request

Behaviour:
- Reset values:
  - state IDLE
  - o_chain_pde=0, o_pwr_state=0, o_busy=0, o_done=0, o_err_timeout=0, o_latency=0
  - o_req_ready=1 from the first cycle after reset release.
- States: IDLE, WAIT, RESP.
- IDLE, handshake (i_req_valid & o_req_ready) at edge T:
  - If i_req_pwr_down == o_pwr_state (no-op): go to RESP; o_done pulses in cycle T+1; o_latency=0; o_chain_pde unchanged.
  - Otherwise: o_chain_pde <= i_req_pwr_down at T; latch target and timeout; clear counter; go to WAIT.
- WAIT, each cycle:
  - cnt_next = cnt+1, saturating at all-ones.
  - If prn_s == target: o_latency <= cnt_next; o_pwr_state <= target; o_done pulse next cycle; go to RESP.
  - Else if timeout != 0 and cnt_next == timeout: o_latency <= cnt_next; o_err_timeout pulse next cycle; go to RESP.
  - On timeout, o_pwr_state is unchanged and o_chain_pde stays at target. Software retries or reverses the transition.
  - A match and a timeout in the same cycle resolve as a match, so done wins.
- RESP: exactly one cycle; the pulse output is high; then go to IDLE. o_req_ready=0.
- prn_s is i_chain_prn directly, or its synchronised copy (see Optional Feature).
- Requests presented while not ready are held by the requester; none are dropped or queued.
- i_req_pwr_down and i_timeout_cycles are ignored except at handshake.
- o_done and o_err_timeout are never high together. Each pulses exactly once per accepted request.
- Reset asserted mid-WAIT: next edge forces all reset values, including o_chain_pde=0, so the chain is commanded to power up. No done or err pulse is produced.
- The counter saturates rather than wraps. With timeout=0 and a stuck chain, the block stays in WAIT indefinitely with o_busy=1.

Optional Feature:
- Macro PVE_L1_PWR_SEQ_PRN_SYNC_EN.
- Defined: i_chain_prn passes through a 2-flop synchroniser (reset value 0) before use as prn_s. Measured o_latency increases by 2 for the same chain delay.
- Undefined: prn_s = i_chain_prn combinationally, and i_chain_prn must be synchronous to i_clk.

Test Plan (feature undefined unless stated):
- Reset, then a power-down request with timeout=100; model drives prn high 10 cycles after pde rises -> pde=1 the edge after accept, o_done single pulse, o_latency=10, o_pwr_state=1, ready low throughout.
- After a confirmed power-down, request power-down again -> no pde change, o_done one cycle after accept, o_latency=0.
- Power-up request with timeout=20; prn stuck high -> o_err_timeout pulses once, o_latency=20, o_pwr_state stays 1, pde=0, back in IDLE.
- prn matches on the exact cycle cnt_next reaches timeout=5 -> o_done (not err), o_latency=5.
- Reset asserted at cycle 3 of WAIT during power-down -> pde=0, o_pwr_state=0, no pulses, ready=1 after release.
- With PVE_L1_PWR_SEQ_PRN_SYNC_EN defined, repeat the first test -> o_latency=12.

Source files
------------

// File: rtl/pve_l1_mem_pwr_seq.sv
// Power daisy-chain initiator for the PVE L1 memory macros: one transition in flight, reports done/timeout/latency.
// Optional: define PVE_L1_PWR_SEQ_PRN_SYNC_EN to pass the chain-tail return through a 2-flop synchroniser.
module pve_l1_mem_pwr_seq #(
    parameter int unsigned NUM_MACRO = 64,
    parameter int unsigned TIMEOUT_W = 16,
    parameter int unsigned LAT_W     = TIMEOUT_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_pwr_down,
    input  logic [TIMEOUT_W-1:0] i_timeout_cycles,
    output logic                 o_chain_pde,
    input  logic                 i_chain_prn,
    output logic                 o_pwr_state,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err_timeout,
    output logic [LAT_W-1:0]     o_latency
);

    localparam int unsigned MIN_LAT_W = $clog2(NUM_MACRO + 1);

    if (LAT_W < MIN_LAT_W) begin : g_lat_w_check
        $error("LAT_W too narrow for NUM_MACRO");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 state;
    logic                   target;
    logic [TIMEOUT_W-1:0]   timeout;
    logic [TIMEOUT_W-1:0]   cnt;
    logic [TIMEOUT_W-1:0]   cnt_next;
    logic                   timeout_hit;
    logic                   prn_s;

`ifdef PVE_L1_PWR_SEQ_PRN_SYNC_EN
    logic [1:0] prn_sync;

    // Return path may be asynchronous to i_clk; adds two cycles of measured latency.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prn_sync <= 2'b00;
        end else begin
            prn_sync <= {prn_sync[0], i_chain_prn};
        end
    end

    assign prn_s = prn_sync[1];
`else
    assign prn_s = i_chain_prn;
`endif

    // Saturating wait counter so a stuck chain with no timeout never wraps.
    assign cnt_next    = (&cnt) ? cnt : cnt + TIMEOUT_W'(1);
    assign timeout_hit = (timeout != '0) && (cnt_next == timeout);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            o_req_ready   <= 1'b1;
            o_chain_pde   <= 1'b0;
            o_pwr_state   <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_err_timeout <= 1'b0;
            o_latency     <= '0;
            target        <= 1'b0;
            timeout       <= '0;
            cnt           <= '0;
        end else begin
            o_done        <= 1'b0;
            o_err_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        o_req_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        if (i_req_pwr_down == o_pwr_state) begin
                            // Already in the requested state: confirm without touching the chain.
                            o_done    <= 1'b1;
                            o_latency <= '0;
                            state     <= S_RESP;
                        end else begin
                            o_chain_pde <= i_req_pwr_down;
                            target      <= i_req_pwr_down;
                            timeout     <= i_timeout_cycles;
                            cnt         <= '0;
                            state       <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt_next;
                    // A match on the timeout cycle still counts as success.
                    if (prn_s == target) begin
                        o_latency   <= LAT_W'(cnt_next);
                        o_pwr_state <= target;
                        o_done      <= 1'b1;
                        state       <= S_RESP;
                    end else if (timeout_hit) begin
                        o_latency     <= LAT_W'(cnt_next);
                        o_err_timeout <= 1'b1;
                        state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    o_req_ready <= 1'b1;
                    o_busy      <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    o_req_ready <= 1'b1;
                    o_busy      <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pve_l1_mem_pwr_seq.sv
// Directed bench for pve_l1_mem_pwr_seq: transaction table plus hand-written reset sequences.
module tb_pve_l1_mem_pwr_seq;

    localparam int unsigned TW = 16;
`ifdef PVE_L1_PWR_SEQ_PRN_SYNC_EN
    localparam int LA = 2;
`else
    localparam int LA = 0;
`endif
    localparam int BUDGET = 300;
    localparam int NVEC   = 7;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_pwr_down;
    logic [TW-1:0] timeout_cycles;
    logic          chain_pde;
    logic          chain_prn;
    logic          pwr_state;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic [TW-1:0] latency;

    pve_l1_mem_pwr_seq #(
        .NUM_MACRO (64),
        .TIMEOUT_W (TW),
        .LAT_W     (TW)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_pwr_down   (req_pwr_down),
        .i_timeout_cycles (timeout_cycles),
        .o_chain_pde      (chain_pde),
        .i_chain_prn      (chain_prn),
        .o_pwr_state      (pwr_state),
        .o_busy           (busy),
        .o_done           (done),
        .o_err_timeout    (err_timeout),
        .o_latency        (latency)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          pwr_down;
        logic [TW-1:0] tmo;
        logic          drive_prn;
        logic          prn_val;
        int            prn_delay;
        logic          exp_done;
        logic          exp_err;
        int            exp_lat;
        logic          exp_state;
        logic          exp_pde;
    } vec_t;

    vec_t vecs[NVEC];
    int   errors;
    int   checks;
    int   n_done;
    int   n_err;
    int   n_both;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) n_done = n_done + 1;
            if (err_timeout) n_err = n_err + 1;
            if (done && err_timeout) n_both = n_both + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int   k;
        bit   seen;
        bit   hs_ok;
        int   pulse_k;
        logic got_done;
        logic got_err;
        int   base_done;
        int   base_err;

        errors = 0; checks = 0; n_done = 0; n_err = 0; n_both = 0;

        //           pd    tmo             drv   val   dly  done  err   lat     state pde
        vecs[0] = '{1'b1, 16'd100,         1'b1, 1'b1, 10, 1'b1, 1'b0, 10 + LA, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 16'd0,           1'b0, 1'b0, 0,  1'b1, 1'b0, 0,       1'b1, 1'b1};
        vecs[2] = '{1'b0, 16'd20,          1'b0, 1'b0, 0,  1'b0, 1'b1, 20,      1'b1, 1'b0};
        vecs[3] = '{1'b0, TW'(5 + LA),     1'b1, 1'b0, 5,  1'b1, 1'b0, 5 + LA,  1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'd0,           1'b1, 1'b1, 1,  1'b1, 1'b0, 1 + LA,  1'b1, 1'b1};
        vecs[5] = '{1'b0, 16'd3,           1'b0, 1'b0, 0,  1'b0, 1'b1, 3,       1'b1, 1'b0};
        vecs[6] = '{1'b1, 16'd7,           1'b0, 1'b0, 0,  1'b1, 1'b0, 0,       1'b1, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_pwr_down = 1'b0;
        timeout_cycles = '0; chain_prn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pde",   32'(chain_pde),   32'd0);
        chk("rst_state", 32'(pwr_state),   32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_err",   32'(err_timeout), 32'd0);
        chk("rst_lat",   32'(latency),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);

        for (int v = 0; v < NVEC; v++) begin
            @(negedge clk);
            chk("pre_ready", 32'(req_ready), 32'd1);
            req_valid      = 1'b1;
            req_pwr_down   = vecs[v].pwr_down;
            timeout_cycles = vecs[v].tmo;
            base_done = n_done;
            base_err  = n_err;
            @(posedge clk);
            #1;
            // Post-accept changes to these inputs must be ignored.
            req_valid      = 1'b0;
            req_pwr_down   = ~vecs[v].pwr_down;
            timeout_cycles = TW'(1);
            chk("accept_pde", 32'(chain_pde), 32'(vecs[v].exp_pde));
            if (vecs[v].drive_prn && vecs[v].prn_delay == 1) chain_prn = vecs[v].prn_val;
            k = 0; seen = 1'b0; hs_ok = 1'b1; pulse_k = -1;
            got_done = 1'b0; got_err = 1'b0;
            while (!seen && k <= BUDGET) begin
                if (req_ready || !busy) hs_ok = 1'b0;
                if (done || err_timeout) begin
                    seen     = 1'b1;
                    pulse_k  = k;
                    got_done = done;
                    got_err  = err_timeout;
                end else begin
                    @(posedge clk);
                    #1;
                    k = k + 1;
                    if (vecs[v].drive_prn && k == vecs[v].prn_delay - 1) chain_prn = vecs[v].prn_val;
                end
            end
            chk("pulse_seen",  32'(seen),      32'd1);
            chk("pulse_cycle", 32'(pulse_k),   32'(vecs[v].exp_lat));
            chk("done",        32'(got_done),  32'(vecs[v].exp_done));
            chk("err_timeout", 32'(got_err),   32'(vecs[v].exp_err));
            chk("latency",     32'(latency),   32'(vecs[v].exp_lat));
            chk("pwr_state",   32'(pwr_state), 32'(vecs[v].exp_state));
            chk("pde",         32'(chain_pde), 32'(vecs[v].exp_pde));
            chk("busy_hold",   32'(hs_ok),     32'd1);
            @(posedge clk);
            #1;
            chk("pulse_clear", 32'({done, err_timeout}), 32'd0);
            chk("ready_back",  32'(req_ready), 32'd1);
            chk("busy_clear",  32'(busy),      32'd0);
            chk("n_done",      32'(n_done - base_done), 32'(vecs[v].exp_done));
            chk("n_err",       32'(n_err - base_err),   32'(vecs[v].exp_err));
        end

        // Reset during a power-down wait: chain commanded back up, no pulse.
        @(negedge clk);
        rst_n = 1'b0;
        chain_prn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b1; req_pwr_down = 1'b1; timeout_cycles = '0;
        base_done = n_done;
        base_err  = n_err;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midwait_pde",  32'(chain_pde), 32'd1);
        chk("midwait_busy", 32'(busy),      32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_pde",   32'(chain_pde),   32'd0);
        chk("midrst_state", 32'(pwr_state),   32'd0);
        chk("midrst_busy",  32'(busy),        32'd0);
        chk("midrst_lat",   32'(latency),     32'd0);
        chk("midrst_pulse", 32'({done, err_timeout}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_ready",  32'(req_ready), 32'd1);
        chk("midrst_ndone",  32'(n_done - base_done), 32'd0);
        chk("midrst_nerr",   32'(n_err - base_err),   32'd0);
        chk("never_both",    32'(n_both), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
